// File: rtl/q_channel_controller.sv
`timescale 1ns/1ps
// q_channel_controller: controller end of a Q-channel low-power handshake.
// Latency: request issued on the edge sampling the IDLE_CYCLES-th idle cycle; exit registered one edge after wake qualifies.
// Backpressure: the device paces the handshake through qacceptn_i (and qdeny_i when built with QCH_DENY_EN).
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   en_i              auto power management enable
//   qactive_i         device activity indication
//   qacceptn_i        device accept (active-low)
//   qdeny_i           device deny (only when QCH_DENY_EN is defined)
//   qreqn_o           quiescence request (active-low, registered)
//   stopped_o         high while STOPPED, drives clock/power gating (registered)
//   state_o           registered state: RUN=0 REQUEST=1 STOPPED=2 EXIT=3 (DENIED=4)
//   proto_err_o       sticky protocol-violation flag
//
// Optional feature macro: QCH_DENY_EN adds the qdeny_i input, the DENIED state
// and widens state_o to 3 bits.
module q_channel_controller #(
  parameter int IDLE_CYCLES     = 8,
  parameter int MIN_STOP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic       qactive_i,
  input  logic       qacceptn_i,
`ifdef QCH_DENY_EN
  input  logic       qdeny_i,
`endif
  output logic       qreqn_o,
  output logic       stopped_o,
`ifdef QCH_DENY_EN
  output logic [2:0] state_o,
`else
  output logic [1:0] state_o,
`endif
  output logic       proto_err_o
);

`ifdef QCH_DENY_EN
  localparam int SW = 3;
`else
  localparam int SW = 2;
`endif

  localparam int IW  = $clog2(IDLE_CYCLES + 1);
  localparam int SCW = $clog2(MIN_STOP_CYCLES + 1);

  // Counter value on the edge that samples the last required idle cycle.
  localparam logic [IW-1:0]  IDLE_LAST = IW'(IDLE_CYCLES - 1);
  // Stop counter value from which a wake request may be honoured.
  localparam logic [SCW-1:0] STOP_LAST = SCW'(MIN_STOP_CYCLES - 1);
  localparam logic [SCW-1:0] STOP_MAX  = SCW'(MIN_STOP_CYCLES);

  typedef enum logic [SW-1:0] {
    ST_RUN     = SW'(0),
    ST_REQUEST = SW'(1),
    ST_STOPPED = SW'(2),
    ST_EXIT    = SW'(3)
`ifdef QCH_DENY_EN
    ,
    ST_DENIED  = SW'(4)
`endif
  } state_t;

  state_t         r_state;
  logic           r_qreqn;
  logic           r_stopped;
  logic           r_err;
  logic [IW-1:0]  r_idle_cnt;
  logic [SCW-1:0] r_stop_cnt;

  logic w_idle;
  logic w_wake;
  logic w_min_done;

  // Idle only counts when management is enabled, the device is quiet and
  // the accept line is in its RUN-state value.
  assign w_idle     = en_i & ~qactive_i & qacceptn_i;
  // Either device activity or software disabling management wakes the channel.
  assign w_wake     = qactive_i | ~en_i;
  assign w_min_done = (r_stop_cnt >= STOP_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_qreqn    <= 1'b1;
      r_stopped  <= 1'b0;
      r_err      <= 1'b0;
      r_idle_cnt <= '0;
      r_stop_cnt <= '0;
    end else begin
      // Both counters are only live in their own state; everywhere else
      // they sit at zero so each state entry starts from a clean count.
      r_idle_cnt <= '0;
      r_stop_cnt <= '0;

      case (r_state)
        ST_RUN: begin
          r_qreqn   <= 1'b1;
          r_stopped <= 1'b0;
          if (!qacceptn_i) begin
            r_err <= 1'b1;
          end
`ifdef QCH_DENY_EN
          if (qdeny_i) begin
            r_err <= 1'b1;
          end
`endif
          if (w_idle) begin
            if (r_idle_cnt == IDLE_LAST) begin
              r_state <= ST_REQUEST;
              r_qreqn <= 1'b0;
            end else begin
              r_idle_cnt <= r_idle_cnt + 1'b1;
            end
          end
        end

        ST_REQUEST: begin
          // A request is never withdrawn by activity or enable; only the
          // device's accept (or deny) resolves it.
          r_qreqn <= 1'b0;
          if (!qacceptn_i) begin
            r_state   <= ST_STOPPED;
            r_stopped <= 1'b1;
`ifdef QCH_DENY_EN
            // Accept and deny together is illegal; accept wins.
            if (qdeny_i) begin
              r_err <= 1'b1;
            end
`endif
          end
`ifdef QCH_DENY_EN
          else if (qdeny_i) begin
            r_state <= ST_DENIED;
            r_qreqn <= 1'b1;
          end
`endif
        end

        ST_STOPPED: begin
          if (qacceptn_i) begin
            r_err <= 1'b1;
          end
          // A wake seen early is simply re-evaluated each cycle, so it is
          // honoured once the minimum residency expires if still present.
          if (w_wake && w_min_done) begin
            r_state   <= ST_EXIT;
            r_qreqn   <= 1'b1;
            r_stopped <= 1'b0;
          end else if (r_stop_cnt != STOP_MAX) begin
            r_stop_cnt <= r_stop_cnt + 1'b1;
          end else begin
            r_stop_cnt <= r_stop_cnt;
          end
        end

        ST_EXIT: begin
          r_qreqn   <= 1'b1;
          r_stopped <= 1'b0;
          if (qacceptn_i) begin
            r_state <= ST_RUN;
          end
        end

`ifdef QCH_DENY_EN
        ST_DENIED: begin
          r_qreqn   <= 1'b1;
          r_stopped <= 1'b0;
          if (!qdeny_i) begin
            r_state <= ST_RUN;
          end
        end
`endif

        default: begin
          r_state   <= ST_RUN;
          r_qreqn   <= 1'b1;
          r_stopped <= 1'b0;
        end
      endcase
    end
  end

  assign qreqn_o     = r_qreqn;
  assign stopped_o   = r_stopped;
  assign state_o     = r_state;
  assign proto_err_o = r_err;

endmodule

// File: tb/tb_q_channel_controller.sv
`timescale 1ns/1ps
module tb_q_channel_controller;

`ifdef QCH_DENY_EN
  localparam int SW = 3;
`else
  localparam int SW = 2;
`endif

  localparam int RUN = 0;
  localparam int REQ = 1;
  localparam int STP = 2;
  localparam int EXT = 3;
  localparam int DEN = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          en_i;
  logic          qactive_i;
  logic          qacceptn_i;
`ifdef QCH_DENY_EN
  logic          qdeny_i;
`endif
  logic          qreqn_o;
  logic          stopped_o;
  logic [SW-1:0] state_o;
  logic          proto_err_o;

  q_channel_controller #(
    .IDLE_CYCLES    (8),
    .MIN_STOP_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en_i       (en_i),
    .qactive_i  (qactive_i),
    .qacceptn_i (qacceptn_i),
`ifdef QCH_DENY_EN
    .qdeny_i    (qdeny_i),
`endif
    .qreqn_o    (qreqn_o),
    .stopped_o  (stopped_o),
    .state_o    (state_o),
    .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [SW-1:0] st;
    logic          qreqn;
    logic          stopped;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_out(input string tag, input int st, input logic qreqn,
                            input logic stopped, input logic err);
    exp_t e;
    e.tag     = tag;
    e.st      = SW'(st);
    e.qreqn   = qreqn;
    e.stopped = stopped;
    e.err     = err;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (state_o === e.st) else begin
        errors++;
        $error("FAIL %s state observed=%0d expected=%0d", e.tag, state_o, e.st);
      end
      checks++;
      assert (qreqn_o === e.qreqn) else begin
        errors++;
        $error("FAIL %s qreqn observed=%0b expected=%0b", e.tag, qreqn_o, e.qreqn);
      end
      checks++;
      assert (stopped_o === e.stopped) else begin
        errors++;
        $error("FAIL %s stopped observed=%0b expected=%0b", e.tag, stopped_o, e.stopped);
      end
      checks++;
      assert (proto_err_o === e.err) else begin
        errors++;
        $error("FAIL %s proto_err observed=%0b expected=%0b", e.tag, proto_err_o, e.err);
      end
    end
  endtask

  // One clock edge with an expected post-edge output set, sampled 1ns later.
  task automatic step(input string tag, input int st, input logic qreqn,
                      input logic stopped, input logic err);
    expect_out(tag, st, qreqn, stopped, err);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    reset      = 1'b1;
    en_i       = 1'b1;
    qactive_i  = 1'b0;
    qacceptn_i = 1'b1;
`ifdef QCH_DENY_EN
    qdeny_i    = 1'b0;
`endif
    #2;
    expect_out("reset", RUN, 1'b1, 1'b0, 1'b0);
    compare_out();
    #10 reset = 1'b0;

    // Eight idle edges: request on the eighth.
    for (int i = 1; i <= 7; i++) step($sformatf("idle%0d", i), RUN, 1'b1, 1'b0, 1'b0);
    step("req_issue", REQ, 1'b0, 1'b0, 1'b0);

    // Activity / enable drop must not abort the request.
    qactive_i = 1'b1; en_i = 1'b0;
    step("req_no_abort", REQ, 1'b0, 1'b0, 1'b0);
    qactive_i = 1'b0; en_i = 1'b1;
    step("req_hold", REQ, 1'b0, 1'b0, 1'b0);

    qacceptn_i = 1'b0;
    step("stop_entry", STP, 1'b0, 1'b1, 1'b0);

    // Early wake is deferred until minimum residency expires.
    qactive_i = 1'b1;
    for (int i = 1; i <= 3; i++) step($sformatf("stop_min%0d", i), STP, 1'b0, 1'b1, 1'b0);
    step("exit_entry", EXT, 1'b1, 1'b0, 1'b0);

    qactive_i = 1'b0;
    for (int i = 1; i <= 5; i++) step($sformatf("exit_wait%0d", i), EXT, 1'b1, 1'b0, 1'b0);
    qacceptn_i = 1'b1;
    step("exit_done", RUN, 1'b1, 1'b0, 1'b0);

    // Seven-cycle idle stretches never reach the threshold.
    for (int i = 0; i < 28; i++) begin
      qactive_i = (((i / 7) % 2) == 1);
      step($sformatf("no_req%0d", i), RUN, 1'b1, 1'b0, 1'b0);
    end
    qactive_i = 1'b0;

    // en_i low clears the idle count.
    for (int i = 1; i <= 5; i++) step($sformatf("pre_en%0d", i), RUN, 1'b1, 1'b0, 1'b0);
    en_i = 1'b0;
    step("en_low", RUN, 1'b1, 1'b0, 1'b0);
    en_i = 1'b1;

    // Accept asserted in RUN is a protocol error (and non-idle).
    qacceptn_i = 1'b0;
    step("proto_run", RUN, 1'b1, 1'b0, 1'b1);
    qacceptn_i = 1'b1;
    for (int i = 1; i <= 7; i++) step($sformatf("idle_again%0d", i), RUN, 1'b1, 1'b0, 1'b1);
    step("req_again", REQ, 1'b0, 1'b0, 1'b1);
    step("req_sticky", REQ, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-REQUEST, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    expect_out("reset_async", RUN, 1'b1, 1'b0, 1'b0);
    compare_out();
    #3 reset = 1'b0;

    // Released accept while STOPPED is a protocol error; no wake, so stay.
    for (int i = 1; i <= 7; i++) step($sformatf("idle_b%0d", i), RUN, 1'b1, 1'b0, 1'b0);
    step("req_b", REQ, 1'b0, 1'b0, 1'b0);
    qacceptn_i = 1'b0;
    step("stop_b", STP, 1'b0, 1'b1, 1'b0);
    qacceptn_i = 1'b1;
    step("proto_stopped", STP, 1'b0, 1'b1, 1'b1);
    step("stopped_sticky", STP, 1'b0, 1'b1, 1'b1);

`ifdef QCH_DENY_EN
    #2 reset = 1'b1;
    qacceptn_i = 1'b1;
    qactive_i  = 1'b0;
    qdeny_i    = 1'b0;
    #2 reset = 1'b0;
    for (int i = 1; i <= 7; i++) step($sformatf("idle_d%0d", i), RUN, 1'b1, 1'b0, 1'b0);
    step("req_d", REQ, 1'b0, 1'b0, 1'b0);
    qdeny_i = 1'b1;
    step("deny", DEN, 1'b1, 1'b0, 1'b0);
    step("deny_hold", DEN, 1'b1, 1'b0, 1'b0);
    qdeny_i = 1'b0;
    step("deny_exit", RUN, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++) step($sformatf("idle_e%0d", i), RUN, 1'b1, 1'b0, 1'b0);
    step("req_e", REQ, 1'b0, 1'b0, 1'b0);
    qdeny_i = 1'b1; qacceptn_i = 1'b0;
    step("deny_and_accept", STP, 1'b0, 1'b1, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
